// File: rtl/bomberman_pkg.sv
// Shared playfield geometry, blast extents and bomb FSM encoding for the
// bomberman slice.
package bomberman_pkg;

  localparam int unsigned MIN_X = 143;
  localparam int unsigned MAX_X = 784;
  localparam int unsigned MIN_Y = 34;
  localparam int unsigned MAX_Y = 516;
  localparam int unsigned TILE  = 16;

  localparam int unsigned E_NEG = 48;
  localparam int unsigned E_POS = 63;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    EXPLODE = 2'b10
  } state_e;

  // Snap a sprite corner to the grid tile under its centre; a centre left of
  // (or above) the playfield edge clamps onto the first tile.
  function automatic logic [9:0] snap(input logic [9:0] pos, input logic [10:0] min_p);
    logic [10:0] centre;
    logic [10:0] off;
    logic [10:0] res;
    centre = {1'b0, pos} + 11'(TILE / 2);
    off    = centre - min_p;
    if (centre < min_p) res = min_p;
    else                res = min_p + (off & ~11'(TILE - 1));
    return res[9:0];
  endfunction

endpackage

// File: rtl/explosion_shape.sv
// Pixel-in-plus test: horizontal and vertical beams of the explosion centred
// on the bomb tile at (e_x_i, e_y_i).
module explosion_shape
  import bomberman_pkg::*;
(
  input  logic [9:0] v_x_i,
  input  logic [9:0] v_y_i,
  input  logic [9:0] e_x_i,
  input  logic [9:0] e_y_i,
  output logic       in_plus_o
);

  localparam logic signed [10:0] NEG  = 11'(E_NEG);
  localparam logic signed [10:0] POS  = 11'(E_POS);
  localparam logic signed [10:0] SPAN = 11'(TILE - 1);

  logic signed [10:0] vx, vy, ex, ey;
  logic               in_h, in_v;

  // Signed so a beam reaching past the left/top screen edge does not wrap.
  assign vx = signed'({1'b0, v_x_i});
  assign vy = signed'({1'b0, v_y_i});
  assign ex = signed'({1'b0, e_x_i});
  assign ey = signed'({1'b0, e_y_i});

  assign in_h = (vx >= ex - NEG) && (vx <= ex + POS) &&
                (vy >= ey)       && (vy <= ey + SPAN);
  assign in_v = (vx >= ex)       && (vx <= ex + SPAN) &&
                (vy >= ey - NEG) && (vy <= ey + POS);

  assign in_plus_o = in_h || in_v;

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb controller: places a bomb on C press, runs the fuse, pulses the
// detonation to the player module and drives the bomb/explosion pixel flags.
module bomb_controller
  import bomberman_pkg::*;
#(
  parameter int unsigned FUSE_TICKS    = 150000000,
  parameter int unsigned EXPLODE_TICKS = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       C,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic       game_over,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  output logic [9:0] e_x,
  output logic [9:0] e_y,
  output logic       explosion_SCEN,
  output logic       bomb_active,
  output logic       bomb_on,
  output logic       explosion_on
);

  localparam int unsigned MAX_T = (FUSE_TICKS > EXPLODE_TICKS) ? FUSE_TICKS : EXPLODE_TICKS;
  localparam int unsigned CW    = (MAX_T < 2) ? 1 : $clog2(MAX_T);
  localparam logic [CW-1:0] FUSE_LAST    = CW'(FUSE_TICKS - 1);
  localparam logic [CW-1:0] EXPLODE_LAST = CW'(EXPLODE_TICKS - 1);

  state_e          state_q;
  logic            c_prev_q;
  logic [CW-1:0]   counter_q;
  logic [9:0]      e_x_q, e_y_q;
  logic            scen_q;
  logic            place;
  logic            in_plus;
  logic [10:0]     vx, vy, ex, ey;

  assign place = C & ~c_prev_q & ~game_over & (state_q == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      c_prev_q  <= 1'b0;
      counter_q <= '0;
      e_x_q     <= '0;
      e_y_q     <= '0;
      scen_q    <= 1'b0;
    end else begin
      c_prev_q <= C;
      scen_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (place) begin
            e_x_q     <= snap(b_x, 11'(MIN_X));
            e_y_q     <= snap(b_y, 11'(MIN_Y));
            counter_q <= '0;
            state_q   <= ARMED;
            scen_q    <= (FUSE_TICKS == 1);
          end
        end
        ARMED: begin
          if (counter_q == FUSE_LAST) begin
            counter_q <= '0;
            state_q   <= EXPLODE;
          end else begin
            counter_q <= counter_q + CW'(1);
            // Registered pulse is raised one edge early so it lands on the last fuse cycle.
            scen_q    <= (counter_q + CW'(1) == FUSE_LAST);
          end
        end
        EXPLODE: begin
          if (counter_q == EXPLODE_LAST) begin
            counter_q <= '0;
            state_q   <= IDLE;
          end else begin
            counter_q <= counter_q + CW'(1);
          end
        end
        default: begin
          counter_q <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign e_x            = e_x_q;
  assign e_y            = e_y_q;
  assign explosion_SCEN = scen_q;
  assign bomb_active    = (state_q == ARMED);

  assign vx = {1'b0, v_x};
  assign vy = {1'b0, v_y};
  assign ex = {1'b0, e_x_q};
  assign ey = {1'b0, e_y_q};

  assign bomb_on = (state_q == ARMED) &&
                   (vx >= ex) && (vx <= ex + 11'(TILE - 1)) &&
                   (vy >= ey) && (vy <= ey + 11'(TILE - 1));

  explosion_shape u_shape (
    .v_x_i     (v_x),
    .v_y_i     (v_y),
    .e_x_i     (e_x_q),
    .e_y_i     (e_y_q),
    .in_plus_o (in_plus)
  );

  assign explosion_on = (state_q == EXPLODE) && in_plus;

endmodule

// File: tb/tb_bomb_controller.sv
// Directed bench for bomb_controller with a short fuse (10) and explosion (5).
module tb_bomb_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       C;
  logic [9:0] b_x, b_y;
  logic       game_over;
  logic [9:0] v_x, v_y;
  logic [9:0] e_x, e_y;
  logic       explosion_SCEN, bomb_active, bomb_on, explosion_on;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bomb_controller #(
    .FUSE_TICKS    (10),
    .EXPLODE_TICKS (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .C              (C),
    .b_x            (b_x),
    .b_y            (b_y),
    .game_over      (game_over),
    .v_x            (v_x),
    .v_y            (v_y),
    .e_x            (e_x),
    .e_y            (e_y),
    .explosion_SCEN (explosion_SCEN),
    .bomb_active    (bomb_active),
    .bomb_on        (bomb_on),
    .explosion_on   (explosion_on)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the placing edge, i.e. in cycle N+1.
  task automatic press();
    C = 1'b1;
    step();
    C = 1'b0;
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (explosion_SCEN) cnt++;
      step();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_active"}, bomb_active, 0);
    check({tag, "_scen"},   explosion_SCEN, 0);
    check({tag, "_bomb_on"}, bomb_on, 0);
    check({tag, "_expl_on"}, explosion_on, 0);
    check({tag, "_ex"}, e_x, 0);
    check({tag, "_ey"}, e_y, 0);
  endtask

  // Full fuse/explosion timeline with the pixel parked on the bomb tile.
  task automatic fuse_run(input logic [9:0] ex, input logic [9:0] ey, input string name);
    v_x = ex;
    v_y = ey;
    press();
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("%s_active_k%0d", name, k),  bomb_active,    (k <= 10));
      check($sformatf("%s_scen_k%0d", name, k),    explosion_SCEN, (k == 10));
      check($sformatf("%s_bomb_on_k%0d", name, k), bomb_on,        (k <= 10));
      check($sformatf("%s_expl_on_k%0d", name, k), explosion_on,   (k >= 11 && k <= 15));
      if (k == 1) begin
        check({name, "_ex"}, e_x, ex);
        check({name, "_ey"}, e_y, ey);
      end
      if (k < 16) step();
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b0; C = 1'b0; game_over = 1'b0;
    b_x = 10'd150; b_y = 10'd40; v_x = '0; v_y = '0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk) reset = 1'b1;
    step();
    step();

    fuse_run(10'd143, 10'd34, "snap1");
    step();

    // Plus shape around (143,34) during EXPLODE
    press();
    for (int i = 0; i < 10; i++) step();
    v_x = 10'd206; v_y = 10'd34; #1 check("shape_206_34", explosion_on, 1);
    v_x = 10'd143; v_y = 10'd97; #1 check("shape_143_97", explosion_on, 1);
    v_x = 10'd207; v_y = 10'd34; #1 check("shape_207_34", explosion_on, 0);
    v_x = 10'd159; v_y = 10'd50; #1 check("shape_159_50", explosion_on, 0);
    step();
    v_x = 10'd100; v_y = 10'd34; #1 check("shape_100_34", explosion_on, 1);
    v_x = 10'd94;  v_y = 10'd34; #1 check("shape_94_34",  explosion_on, 0);
    for (int i = 0; i < 6; i++) step();
    check("shape_back_idle", bomb_active | explosion_on, 0);

    // Clamp when the centre lies left of / above the playfield
    b_x = 10'd100; b_y = 10'd10;
    press();
    check("clamp_ex", e_x, 143);
    check("clamp_ey", e_y, 34);
    for (int i = 0; i < 16; i++) step();
    b_x = 10'd150; b_y = 10'd40;

    // Holding C gives exactly one bomb
    C = 1'b1;
    count_pulses(30, cnt);
    check("hold_pulses", cnt, 1);
    C = 1'b0;
    step();
    step();

    // Second press while armed is ignored
    press();
    step();
    step();
    press();
    count_pulses(25, cnt);
    check("rearm_pulses", cnt, 1);
    check("rearm_idle", bomb_active, 0);

    fuse_run(10'd143, 10'd34, "again");
    step();

    // game_over blocks placement
    game_over = 1'b1;
    press();
    check("go_block_active", bomb_active, 0);
    count_pulses(20, cnt);
    check("go_block_pulses", cnt, 0);
    game_over = 1'b0;
    step();

    // game_over during the fuse does not stop the pulse
    press();
    step();
    step();
    game_over = 1'b1;
    for (int k = 3; k <= 16; k++) begin
      check($sformatf("go_armed_scen_k%0d", k), explosion_SCEN, (k == 10));
      step();
    end
    game_over = 1'b0;
    step();

    // Reset mid-fuse
    b_x = 10'd152; b_y = 10'd51;
    v_x = 10'd159; v_y = 10'd50;
    press();
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_bomb_on", bomb_on, 1);
    #2 reset = 1'b0;
    #1 check_idle_outputs("midreset");
    count_pulses(3, cnt);
    check("midreset_hold_pulses", cnt, 0);
    @(negedge clk) reset = 1'b1;
    step();
    count_pulses(20, cnt);
    check("after_reset_pulses", cnt, 0);

    fuse_run(10'd159, 10'd50, "snap2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bomb_controller.md
Name: bomb_controller

Overview:
- Producer end of the explosion interface consumed by the player module (e_x, e_y, explosion_SCEN).
- On a press of the action button C, it places one bomb on the 16x16 tile nearest the player's sprite position.
- It then runs a fuse timer, issues a single-cycle explosion pulse with the bomb coordinates, and holds a visible explosion for a fixed time.
- It also provides per-pixel bomb_on / explosion_on flags to the top module's colour mux.

Parameters:
- FUSE_TICKS, 150000000, clock cycles from placement to detonation (1.5 s at 100 MHz).
- EXPLODE_TICKS, 50000000, clock cycles the explosion stays visible.
- MIN_X, 143, left edge of the playfield in pixels.
- MIN_Y, 34, top edge of the playfield in pixels.
- TILE, 16, tile and sprite size in pixels.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- C  in  1  bomb button, level, already debounced
- b_x  in  10  player sprite top-left x
- b_y  in  10  player sprite top-left y
- game_over  in  1  blocks new placements while high
- v_x  in  10  current pixel x
- v_y  in  10  current pixel y
- e_x  out  10  bomb or explosion tile top-left x
- e_y  out  10  bomb or explosion tile top-left y
- explosion_SCEN  out  1  one-cycle detonation pulse
- bomb_active  out  1  high in ARMED
- bomb_on  out  1  current pixel is inside the armed bomb tile
- explosion_on  out  1  current pixel is inside the plus-shaped explosion

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0; e_x=e_y=0; counter=0; C edge-detect register=0.
- Edge detect:
  - c_prev is registered each cycle.
  - place = C & ~c_prev & ~game_over & (state==IDLE).
  - Holding C never re-triggers; it needs a release and a new press.
- Tile snap (11-bit unsigned arithmetic):
  - e_x <= MIN_X + ((b_x + TILE/2 - MIN_X) & ~(TILE-1)).
  - e_y is computed the same way from b_y and MIN_Y.
  - If b_x + TILE/2 < MIN_X, the result is clamped to MIN_X; same rule for y.
- IDLE:
  - On place (cycle N): latch e_x/e_y, counter<=0, go to ARMED at N+1.
  - C during ARMED or EXPLODE is ignored (one bomb at a time).
- ARMED:
  - counter increments each cycle.
  - When counter==FUSE_TICKS-1: explosion_SCEN=1 for exactly that cycle (cycle N+FUSE_TICKS), counter<=0, go to EXPLODE.
  - e_x/e_y are stable from N+1 until the next placement.
- EXPLODE:
  - counter increments; when counter==EXPLODE_TICKS-1, go to IDLE and clear counter.
- game_over rising while ARMED:
  - The fuse completes normally, including the pulse.
  - Only new placements are inhibited.
- Reset mid-fuse or mid-explosion: no pulse; outputs return to reset values immediately.
- explosion_SCEN is registered (glitch-free) and is never high outside the ARMED->EXPLODE transition cycle.
- bomb_on (combinational from registered state):
  - (state==ARMED) & v_x in [e_x, e_x+15] & v_y in [e_y, e_y+15].
- explosion_on, state==EXPLODE and (H or V):
  - H: v_x in [e_x-48, e_x+63] and v_y in [e_y, e_y+15].
  - V: v_x in [e_x, e_x+15] and v_y in [e_y-48, e_y+63].
  - All comparisons use 11-bit signed arithmetic so e_x-48 below 0 does not wrap.

Decomposition:
- Shared package (bomberman_pkg):
  - Playfield constants MIN_X, MAX_X=784, MIN_Y, MAX_Y=516, TILE.
  - Blast extents E_NEG=48, E_POS=63.
  - State encoding IDLE=2'b00, ARMED=2'b01, EXPLODE=2'b10.
- One natural sub-module, explosion_shape: purely combinational pixel-in-plus test taking v_x, v_y, e_x, e_y.

Test Plan (bench overrides FUSE_TICKS=10, EXPLODE_TICKS=5):
- Snap: b_x=150,b_y=40, pulse C -> e_x=143,e_y=34. Then b_x=152,b_y=51 on the next bomb -> e_x=159,e_y=50.
- Fuse timing: C rises at cycle N -> bomb_active=1 from N+1; explosion_SCEN=1 only at N+10; explosion_on region live N+11..N+15; IDLE at N+16.
- Re-trigger: C held high 30 cycles, then a second press during ARMED -> exactly one explosion_SCEN pulse; a fresh press after IDLE -> second pulse.
- game_over=1 before the press -> no placement, bomb_active stays 0. game_over=1 during ARMED -> pulse still occurs at N+10.
- Reset low at N+5 -> all outputs 0 at once, no pulse ever; release reset -> IDLE accepts a new press.
- Shape with e_x=143,e_y=34 in EXPLODE:
  - v=(206,34) and v=(143,97) -> explosion_on=1.
  - v=(207,34) and v=(159,50) -> explosion_on=0.
  - v=(100,34) -> explosion_on=1 (left beam, no wrap).
